// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, forwarding source codes and
// the operation code used for pipeline bubbles.
package cpu_pkg;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SLL    = 6'b000001;
  localparam logic [5:0] ALU_SLT    = 6'b000010;
  localparam logic [5:0] ALU_SLTU   = 6'b000011;
  localparam logic [5:0] ALU_XOR    = 6'b000100;
  localparam logic [5:0] ALU_SRL    = 6'b000101;
  localparam logic [5:0] ALU_OR     = 6'b000110;
  localparam logic [5:0] ALU_AND    = 6'b000111;
  localparam logic [5:0] ALU_MUL    = 6'b001000;
  localparam logic [5:0] ALU_MULH   = 6'b001001;
  localparam logic [5:0] ALU_MULHSU = 6'b001010;
  localparam logic [5:0] ALU_MULHU  = 6'b001011;
  localparam logic [5:0] ALU_DIV    = 6'b001100;
  localparam logic [5:0] ALU_DIVU   = 6'b001101;
  localparam logic [5:0] ALU_REM    = 6'b001110;
  localparam logic [5:0] ALU_REMU   = 6'b001111;
  localparam logic [5:0] ALU_SUB    = 6'b010000;
  localparam logic [5:0] ALU_SRA    = 6'b010101;
  localparam logic [5:0] ALU_FWD    = 6'b011000;

  // Operand source reported on fwd_a / fwd_b
  localparam logic [1:0] FWD_SRC_REG   = 2'b00;
  localparam logic [1:0] FWD_SRC_MEMWB = 2'b01;
  localparam logic [1:0] FWD_SRC_EXMEM = 2'b10;

  // A bubble executes as a harmless ADD
  localparam logic [5:0] BUBBLE_ALU_SEL = ALU_ADD;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight producer of a source
// register (EX/MEM over MEM/WB), falling back to the latched register value.
// x0 is never forwarded, and an invalid stage always reports the register path.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              stage_valid,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   reg_data,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   operand,
  output logic [1:0]        src
);

  logic ex_hit_s;
  logic wb_hit_s;

  // A later stage supplies rs when it writes a non-zero rd equal to rs
  function automatic logic producer_hit(input logic              we,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] rs);
    return we && (rd != {REG_AW{1'b0}}) && (rd == rs);
  endfunction

  // Select the forwarding source and the resulting operand
  always_comb begin
    ex_hit_s = producer_hit(exmem_we, exmem_rd, rs_addr);
    wb_hit_s = producer_hit(memwb_we, memwb_rd, rs_addr);
    src      = FWD_SRC_REG;
    operand  = reg_data;
    if (!stage_valid) begin
      src     = FWD_SRC_REG;
      operand = reg_data;
    end else if (ex_hit_s) begin
      src     = FWD_SRC_EXMEM;
      operand = exmem_result;
    end else if (wb_hit_s) begin
      src     = FWD_SRC_MEMWB;
      operand = memwb_result;
    end else begin
      src     = FWD_SRC_REG;
      operand = reg_data;
    end
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register feeding the ALU. Latches the decoded instruction,
// resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and supports
// hold (stall) and bubble insertion (flush, or an invalid decode slot).
module id_ex_pipeline_reg
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [SEL_W-1:0]  id_alu_select,
  input  logic              id_op1_sel,
  input  logic              id_op2_sel,
  input  logic              id_reg_we,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              exmem_we,
  input  logic              memwb_we,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_data1,
  output logic [XLEN-1:0]   alu_data2,
  output logic [SEL_W-1:0]  alu_select,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_we,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // Stage registers
  logic              valid_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   rs1_data_r;
  logic [XLEN-1:0]   rs2_data_r;
  logic [XLEN-1:0]   imm_r;
  logic [REG_AW-1:0] rs1_addr_r;
  logic [REG_AW-1:0] rs2_addr_r;
  logic [REG_AW-1:0] rd_addr_r;
  logic [SEL_W-1:0]  alu_sel_r;
  logic              op1_sel_r;
  logic              op2_sel_r;
  logic              reg_we_r;
  logic              mem_read_r;
  logic              mem_write_r;

  logic              load_en_s;
  logic              bubble_s;
  logic [XLEN-1:0]   rs1_fwd_s;
  logic [XLEN-1:0]   rs2_fwd_s;
  logic [1:0]        fwd_a_s;
  logic [1:0]        fwd_b_s;

  // Decide whether the stage updates this edge and whether it takes a bubble;
  // flush overrides stall, and an empty decode slot also becomes a bubble
  always_comb begin
    load_en_s = 1'b0;
    bubble_s  = 1'b0;
    if (flush) begin
      load_en_s = 1'b1;
      bubble_s  = 1'b1;
    end else if (stall) begin
      load_en_s = 1'b0;
      bubble_s  = 1'b0;
    end else begin
      load_en_s = 1'b1;
      bubble_s  = !id_valid;
    end
  end

  // Stage register update: async clear, then bubble / hold / load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r     <= 1'b0;
      pc_r        <= {XLEN{1'b0}};
      rs1_data_r  <= {XLEN{1'b0}};
      rs2_data_r  <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      rs1_addr_r  <= {REG_AW{1'b0}};
      rs2_addr_r  <= {REG_AW{1'b0}};
      rd_addr_r   <= {REG_AW{1'b0}};
      alu_sel_r   <= SEL_W'(BUBBLE_ALU_SEL);
      op1_sel_r   <= 1'b0;
      op2_sel_r   <= 1'b0;
      reg_we_r    <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (load_en_s) begin
      if (bubble_s) begin
        valid_r     <= 1'b0;
        pc_r        <= {XLEN{1'b0}};
        rs1_data_r  <= {XLEN{1'b0}};
        rs2_data_r  <= {XLEN{1'b0}};
        imm_r       <= {XLEN{1'b0}};
        rs1_addr_r  <= {REG_AW{1'b0}};
        rs2_addr_r  <= {REG_AW{1'b0}};
        rd_addr_r   <= {REG_AW{1'b0}};
        alu_sel_r   <= SEL_W'(BUBBLE_ALU_SEL);
        op1_sel_r   <= 1'b0;
        op2_sel_r   <= 1'b0;
        reg_we_r    <= 1'b0;
        mem_read_r  <= 1'b0;
        mem_write_r <= 1'b0;
      end else begin
        valid_r     <= 1'b1;
        pc_r        <= id_pc;
        rs1_data_r  <= id_rs1_data;
        rs2_data_r  <= id_rs2_data;
        imm_r       <= id_imm;
        rs1_addr_r  <= id_rs1_addr;
        rs2_addr_r  <= id_rs2_addr;
        rd_addr_r   <= id_rd_addr;
        alu_sel_r   <= id_alu_select;
        op1_sel_r   <= id_op1_sel;
        op2_sel_r   <= id_op2_sel;
        reg_we_r    <= id_reg_we;
        mem_read_r  <= id_mem_read;
        mem_write_r <= id_mem_write;
      end
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
    .stage_valid  (valid_r),
    .rs_addr      (rs1_addr_r),
    .reg_data     (rs1_data_r),
    .exmem_we     (exmem_we),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_we     (memwb_we),
    .memwb_rd     (memwb_rd),
    .memwb_result (memwb_result),
    .operand      (rs1_fwd_s),
    .src          (fwd_a_s)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
    .stage_valid  (valid_r),
    .rs_addr      (rs2_addr_r),
    .reg_data     (rs2_data_r),
    .exmem_we     (exmem_we),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_we     (memwb_we),
    .memwb_rd     (memwb_rd),
    .memwb_result (memwb_result),
    .operand      (rs2_fwd_s),
    .src          (fwd_b_s)
  );

  // ALU operand selection: PC / immediate paths override the forwarded values
  always_comb begin
    alu_data1 = rs1_fwd_s;
    alu_data2 = rs2_fwd_s;
    if (op1_sel_r) begin
      alu_data1 = pc_r;
    end else begin
      alu_data1 = rs1_fwd_s;
    end
    if (op2_sel_r) begin
      alu_data2 = imm_r;
    end else begin
      alu_data2 = rs2_fwd_s;
    end
  end

  assign ex_valid      = valid_r;
  assign alu_select    = alu_sel_r;
  assign ex_rd_addr    = rd_addr_r;
  assign ex_reg_we     = reg_we_r;
  assign ex_mem_read   = mem_read_r;
  assign ex_mem_write  = mem_write_r;
  assign ex_store_data = rs2_fwd_s;
  assign fwd_a         = fwd_a_s;
  assign fwd_b         = fwd_b_s;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Testbench for id_ex_pipeline_reg: vector table with a scoreboard queue,
// plus hand-written sequences for mid-cycle forwarding and reset mid-stall.
module tb_id_ex_pipeline_reg;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [5:0]  id_alu_select;
  logic        id_op1_sel, id_op2_sel, id_reg_we, id_mem_read, id_mem_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_we, memwb_we;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] alu_data1, alu_data2, ex_store_data;
  logic [5:0]  alu_select;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_we, ex_mem_read, ex_mem_write;
  logic [1:0]  fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    // stimulus
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  a1, a2, rd;
    logic [5:0]  sel;
    logic        o1, o2, we, mr, mw, stall, flush;
    logic [4:0]  xrd, wrd;
    logic        xwe, wwe;
    logic [31:0] xres, wres;
    // expected outputs
    logic        e_v;
    logic [31:0] e_d1, e_d2, e_st;
    logic [5:0]  e_sel;
    logic [4:0]  e_rd;
    logic        e_we, e_mr, e_mw;
    logic [1:0]  e_fa, e_fb;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];
  vec_t sb [$];

  id_ex_pipeline_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_select(id_alu_select), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
    .id_reg_we(id_reg_we), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.v;   id_pc = v.pc;   id_rs1_data = v.d1; id_rs2_data = v.d2;
    id_imm = v.imm;   id_rs1_addr = v.a1; id_rs2_addr = v.a2; id_rd_addr = v.rd;
    id_alu_select = v.sel; id_op1_sel = v.o1; id_op2_sel = v.o2;
    id_reg_we = v.we; id_mem_read = v.mr; id_mem_write = v.mw;
    stall = v.stall;  flush = v.flush;
    exmem_rd = v.xrd; exmem_we = v.xwe; exmem_result = v.xres;
    memwb_rd = v.wrd; memwb_we = v.wwe; memwb_result = v.wres;
  endtask

  task automatic cmp_all(input vec_t e, input int idx);
    chk($sformatf("r%0d ex_valid", idx),     32'(ex_valid),      32'(e.e_v));
    chk($sformatf("r%0d alu_data1", idx),    alu_data1,          e.e_d1);
    chk($sformatf("r%0d alu_data2", idx),    alu_data2,          e.e_d2);
    chk($sformatf("r%0d alu_select", idx),   32'(alu_select),    32'(e.e_sel));
    chk($sformatf("r%0d ex_rd_addr", idx),   32'(ex_rd_addr),    32'(e.e_rd));
    chk($sformatf("r%0d ex_reg_we", idx),    32'(ex_reg_we),     32'(e.e_we));
    chk($sformatf("r%0d ex_mem_read", idx),  32'(ex_mem_read),   32'(e.e_mr));
    chk($sformatf("r%0d ex_mem_write", idx), 32'(ex_mem_write),  32'(e.e_mw));
    chk($sformatf("r%0d ex_store_data", idx), ex_store_data,     e.e_st);
    chk($sformatf("r%0d fwd_a", idx),        32'(fwd_a),         32'(e.e_fa));
    chk($sformatf("r%0d fwd_b", idx),        32'(fwd_b),         32'(e.e_fb));
  endtask

  initial begin
    vec_t v;
    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) tv[i] = '0;
    // 0: ADD x3,x1,x2 with x1=5, x2=7
    v = '0; v.v = 1'b1; v.a1 = 5'd1; v.d1 = 32'd5; v.a2 = 5'd2; v.d2 = 32'd7; v.rd = 5'd3;
    v.sel = ALU_ADD; v.we = 1'b1;
    v.e_v = 1'b1; v.e_d1 = 32'd5; v.e_d2 = 32'd7; v.e_rd = 5'd3; v.e_we = 1'b1; v.e_st = 32'd7;
    tv[0] = v;
    // 1: SUB with rs1=x4 produced by both EX/MEM and MEM/WB -> EX/MEM wins
    v = '0; v.v = 1'b1; v.a1 = 5'd4; v.d1 = 32'd1; v.a2 = 5'd5; v.d2 = 32'd9; v.rd = 5'd6;
    v.sel = ALU_SUB; v.we = 1'b1;
    v.xrd = 5'd4; v.xwe = 1'b1; v.xres = 32'hAA; v.wrd = 5'd4; v.wwe = 1'b1; v.wres = 32'hBB;
    v.e_v = 1'b1; v.e_d1 = 32'hAA; v.e_d2 = 32'd9; v.e_sel = ALU_SUB; v.e_rd = 5'd6;
    v.e_we = 1'b1; v.e_st = 32'd9; v.e_fa = 2'b10;
    tv[1] = v;
    // 2: stall holds the SUB; EX/MEM drops its write enable -> MEM/WB supplies
    v = '0; v.v = 1'b1; v.a1 = 5'd9; v.d1 = 32'h99; v.rd = 5'd1; v.sel = ALU_XOR; v.stall = 1'b1;
    v.xrd = 5'd4; v.xwe = 1'b0; v.xres = 32'hAA; v.wrd = 5'd4; v.wwe = 1'b1; v.wres = 32'hBB;
    v.e_v = 1'b1; v.e_d1 = 32'hBB; v.e_d2 = 32'd9; v.e_sel = ALU_SUB; v.e_rd = 5'd6;
    v.e_we = 1'b1; v.e_st = 32'd9; v.e_fa = 2'b01;
    tv[2] = v;
    // 3: x0 guard on rs2
    v = '0; v.v = 1'b1; v.a1 = 5'd7; v.d1 = 32'h11; v.rd = 5'd2; v.sel = ALU_OR; v.we = 1'b1;
    v.xrd = 5'd0; v.xwe = 1'b1; v.xres = 32'hFFFF_FFFF; v.wrd = 5'd0; v.wwe = 1'b1; v.wres = 32'h77;
    v.e_v = 1'b1; v.e_d1 = 32'h11; v.e_sel = ALU_OR; v.e_rd = 5'd2; v.e_we = 1'b1;
    tv[3] = v;
    // 4: ADDI: immediate on ALU_DATA2, store data still forwarded rs2
    v = '0; v.v = 1'b1; v.a1 = 5'd1; v.d1 = 32'd3; v.a2 = 5'd8; v.d2 = 32'h20;
    v.imm = 32'hFFFF_FFFC; v.o2 = 1'b1; v.rd = 5'd4; v.we = 1'b1;
    v.wrd = 5'd8; v.wwe = 1'b1; v.wres = 32'h55;
    v.e_v = 1'b1; v.e_d1 = 32'd3; v.e_d2 = 32'hFFFF_FFFC; v.e_rd = 5'd4; v.e_we = 1'b1;
    v.e_st = 32'h55; v.e_fb = 2'b01;
    tv[4] = v;
    // 5: AUIPC: PC on ALU_DATA1
    v = '0; v.v = 1'b1; v.pc = 32'h100; v.o1 = 1'b1; v.o2 = 1'b1; v.imm = 32'h1000;
    v.rd = 5'd9; v.we = 1'b1;
    v.e_v = 1'b1; v.e_d1 = 32'h100; v.e_d2 = 32'h1000; v.e_rd = 5'd9; v.e_we = 1'b1;
    tv[5] = v;
    // 6: ID_VALID=0 loads a bubble
    v = '0; v.v = 1'b0; v.pc = 32'h200; v.a1 = 5'd3; v.d1 = 32'h33; v.rd = 5'd7;
    v.we = 1'b1; v.mr = 1'b1; v.mw = 1'b1; v.sel = ALU_SLL;
    v.xrd = 5'd3; v.xwe = 1'b1; v.xres = 32'h66;
    tv[6] = v;
    // 7: ADD x12,x10,x11
    v = '0; v.v = 1'b1; v.a1 = 5'd10; v.d1 = 32'h30; v.a2 = 5'd11; v.d2 = 32'h40;
    v.rd = 5'd12; v.we = 1'b1;
    v.e_v = 1'b1; v.e_d1 = 32'h30; v.e_d2 = 32'h40; v.e_rd = 5'd12; v.e_we = 1'b1; v.e_st = 32'h40;
    tv[7] = v;
    // 8..10: stall three cycles while ID changes
    v = '0; v.v = 1'b1; v.a1 = 5'd1; v.d1 = 32'd1; v.a2 = 5'd1; v.d2 = 32'd1; v.rd = 5'd1;
    v.sel = ALU_SRA; v.mw = 1'b1; v.stall = 1'b1;
    v.e_v = 1'b1; v.e_d1 = 32'h30; v.e_d2 = 32'h40; v.e_rd = 5'd12; v.e_we = 1'b1; v.e_st = 32'h40;
    tv[8] = v;
    v.pc = 32'd4; v.a1 = 5'd2; v.d1 = 32'd2; v.rd = 5'd2; v.sel = ALU_DIV;
    tv[9] = v;
    v.a1 = 5'd3; v.rd = 5'd3; v.sel = ALU_MUL;
    v.xrd = 5'd10; v.xwe = 1'b1; v.xres = 32'h12; v.e_d1 = 32'h12; v.e_fa = 2'b10;
    tv[10] = v;
    // 11: FLUSH and STALL together with a valid store in ID -> bubble
    v = '0; v.v = 1'b1; v.a1 = 5'd2; v.d1 = 32'h1000; v.a2 = 5'd3; v.d2 = 32'hDEAD;
    v.imm = 32'd8; v.o2 = 1'b1; v.mw = 1'b1; v.sel = ALU_AND; v.flush = 1'b1; v.stall = 1'b1;
    tv[11] = v;
    // 12: the store proper, store data forwarded from EX/MEM
    v.flush = 1'b0; v.stall = 1'b0; v.sel = ALU_ADD;
    v.xrd = 5'd3; v.xwe = 1'b1; v.xres = 32'hBEEF;
    v.e_v = 1'b1; v.e_d1 = 32'h1000; v.e_d2 = 32'd8; v.e_mw = 1'b1; v.e_st = 32'hBEEF; v.e_fb = 2'b10;
    tv[12] = v;
    // 13: load
    v = '0; v.v = 1'b1; v.a1 = 5'd2; v.d1 = 32'h2000; v.imm = 32'd4; v.o2 = 1'b1;
    v.rd = 5'd5; v.we = 1'b1; v.mr = 1'b1;
    v.e_v = 1'b1; v.e_d1 = 32'h2000; v.e_d2 = 32'd4; v.e_rd = 5'd5; v.e_we = 1'b1; v.e_mr = 1'b1;
    tv[13] = v;
    // 14: FLUSH alone
    v = '0; v.v = 1'b1; v.a1 = 5'd1; v.d1 = 32'd5; v.rd = 5'd3; v.we = 1'b1; v.sel = ALU_SUB;
    v.flush = 1'b1;
    tv[14] = v;

    // ---------------- reset with random ID inputs ----------------
    v = '0;
    drive(v);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      id_valid = 1'b1; id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_imm = $urandom; id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom);
      id_rd_addr = 5'($urandom); id_alu_select = 6'($urandom_range(1, 63));
      id_reg_we = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1;
    end
    @(posedge clk); #1;
    chk("reset ex_valid",   32'(ex_valid),   32'd0);
    chk("reset ex_reg_we",  32'(ex_reg_we),  32'd0);
    chk("reset alu_select", 32'(alu_select), 32'd0);
    chk("reset alu_data1",  alu_data1,       32'd0);
    chk("reset alu_data2",  alu_data2,       32'd0);
    chk("reset mem_write",  32'(ex_mem_write), 32'd0);
    @(negedge clk);
    drive(v);
    reset = 1'b1;

    // ---------------- table loop via scoreboard ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      sb.push_back(tv[i]);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard empty at row %0d", i);
      end else begin
        cmp_all(sb.pop_front(), i);
      end
    end

    // ---------------- forwarding tracks mid-cycle while stalled ----------------
    @(negedge clk);
    v = tv[7];
    drive(v);
    @(posedge clk); #1;
    chk("seq load alu_data1", alu_data1, 32'h30);
    @(negedge clk);
    stall = 1'b1; exmem_rd = 5'd10; exmem_we = 1'b1; exmem_result = 32'h12;
    #1;
    chk("seq stall fwd alu_data1", alu_data1, 32'h12);
    chk("seq stall fwd_a", 32'(fwd_a), 32'd2);
    exmem_result = 32'h34;
    #1;
    chk("seq stall track alu_data1", alu_data1, 32'h34);
    chk("seq stall hold rd", 32'(ex_rd_addr), 32'd12);

    // ---------------- asynchronous reset mid-stall ----------------
    reset = 1'b0;
    #1;
    chk("seq rst ex_valid",  32'(ex_valid),  32'd0);
    chk("seq rst ex_reg_we", 32'(ex_reg_we), 32'd0);
    chk("seq rst alu_data1", alu_data1,      32'd0);
    chk("seq rst fwd_a",     32'(fwd_a),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(tv[0]);
    @(posedge clk); #1;
    chk("seq post-rst ex_valid",  32'(ex_valid),   32'd1);
    chk("seq post-rst alu_data1", alu_data1,       32'd5);
    chk("seq post-rst alu_data2", alu_data2,       32'd7);
    chk("seq post-rst rd",        32'(ex_rd_addr), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
